memory_arbiter_rr: RTL and testbench

- Parametrised N-CPU memory arbiter. Sits between CPUS pairs of instruction/data caches and a single-ported RAM.
- Generalises the fixed two-CPU controller with:
  - configurable CPU count and word/address widths;
  - fair round-robin arbitration across CPUs, with data-over-instruction priority within a CPU;
  - registered grant and latched address/store data;
  - RAM error and abort handling.

---
 rtl/memory_arbiter_rr.sv | 146 ++++++++++++++
 tb/tb_memory_arbiter_rr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter: CPUS x {instruction, data} requesters share one single-ported RAM, one transfer at a time.
// The RAM enable asserts one cycle after a request. The wait pulse is combinational on ACCESS, and waits stay high while the RAM reports FREE or BUSY.
module memory_arbiter_rr #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*ADDR_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*ADDR_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic                     memerr
);
  localparam int              ID_W    = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [ID_W:0]   CPUS_W  = (ID_W+1)'(CPUS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(CPUS - 1);
  localparam logic [1:0]      RAM_ACCESS = 2'd2;
  localparam logic [1:0]      RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_nxt, gnt_id, gnt_inc, sel_id, scan_idx;
  logic [ID_W:0]     scan_sum;
  logic              sel_found, sel_d, sel_wr, gnt_d, gnt_wr, gnt_line;
  logic [ADDR_W-1:0] sel_addr, lat_addr;
  logic [WORD_W-1:0] sel_store, lat_store;
  logic [CPUS-1:0]   any_req;

  assign any_req  = iREN | dREN | dWEN;
  assign gnt_inc  = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
  assign ramaddr  = lat_addr;
  assign ramstore = lat_store;

  // Scan from rr_ptr upwards (wrapping) and take the first CPU with any request.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < CPUS; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= CPUS_W) scan_sum = scan_sum - CPUS_W;
      scan_idx = scan_sum[ID_W-1:0];
      for (int j = 0; j < CPUS; j++) begin
        if (!sel_found && (ID_W'(j) == scan_idx) && any_req[j]) begin
          sel_found = 1'b1;
          sel_id    = scan_idx;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    memerr    = 1'b0;
    iwait     = '1;
    dwait     = '1;
    iload     = '0;
    dload     = '0;
    sel_d     = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_store = '0;
    gnt_line  = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      if (ID_W'(i) == sel_id) begin
        sel_d     = dREN[i] | dWEN[i];
        sel_wr    = dWEN[i];
        sel_addr  = sel_d ? daddr[i*ADDR_W +: ADDR_W] : iaddr[i*ADDR_W +: ADDR_W];
        sel_store = dWEN[i] ? dstore[i*WORD_W +: WORD_W] : '0;
      end
      if (ID_W'(i) == gnt_id)
        gnt_line = gnt_d ? (dREN[i] | dWEN[i]) : iREN[i];
    end
    case (state)
      IDLE: if (sel_found) state_nxt = SERVE;
      SERVE: begin
        ramREN = !gnt_wr;
        ramWEN = gnt_wr;
        // A withdrawn request wins over any RAM status: no pulse, pointer untouched.
        if (!gnt_line) begin
          state_nxt = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          state_nxt = IDLE;
          rr_nxt    = gnt_inc;
          for (int i = 0; i < CPUS; i++) begin
            if (ID_W'(i) == gnt_id) begin
              if (gnt_d) begin
                dwait[i] = 1'b0;
                if (!gnt_wr) dload[i*WORD_W +: WORD_W] = ramload;
              end else begin
                iwait[i] = 1'b0;
                iload[i*WORD_W +: WORD_W] = ramload;
              end
            end
          end
        end else if (ramstate == RAM_ERROR) begin
          memerr    = 1'b1;
          state_nxt = IDLE;
          rr_nxt    = gnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      gnt_d     <= 1'b0;
      gnt_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_store <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      if (state == IDLE && sel_found) begin
        gnt_id    <= sel_id;
        gnt_d     <= sel_d;
        gnt_wr    <= sel_wr;
        lat_addr  <= sel_addr;
        lat_store <= sel_store;
      end
    end
  end
endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Bench for memory_arbiter_rr with four CPUs and a latency-programmable RAM model.
// Expected completions are queued in the order they should be served.
module tb_memory_arbiter_rr;
  localparam int N = 4;
  localparam int W = 32;
  localparam int A = 32;

  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0]   iREN, dREN, dWEN, iwait, dwait;
  logic [N*A-1:0] iaddr, daddr;
  logic [N*W-1:0] dstore, iload, dload;
  logic           ramREN, ramWEN, memerr;
  logic [A-1:0]   ramaddr;
  logic [W-1:0]   ramstore, ramload;
  logic [1:0]     ramstate;

  memory_arbiter_rr #(.CPUS(N), .WORD_W(W), .ADDR_W(A)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           cpu;
    bit           is_d;
    bit           wr;
    bit           err;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         lat = 0;
  int         err_at = -1;
  int         busy_cnt, resp_n;
  bit         auto_drop = 1'b1;
  logic [N-1:0] drop_d = '0, drop_i = '0;

  function automatic logic [W-1:0] rd_data(input logic [A-1:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic exp_t mk(input int cpu, input bit is_d, input bit wr, input bit err,
                              input logic [A-1:0] addr, input logic [W-1:0] data);
    exp_t e;
    e.cpu = cpu; e.is_d = is_d; e.wr = wr; e.err = err; e.addr = addr; e.data = data;
    return e;
  endfunction

  // RAM model: BUSY for 'lat' cycles after an enable, then ACCESS (or ERROR on response number err_at).
  assign ramload  = rd_data(ramaddr);
  assign ramstate = !(ramREN | ramWEN) ? 2'd0 :
                    (busy_cnt < lat)   ? 2'd1 :
                    (resp_n == err_at) ? 2'd3 : 2'd2;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_cnt <= 0;
      resp_n   <= 0;
    end else if (ramstate == 2'd1) begin
      busy_cnt <= busy_cnt + 1;
    end else begin
      busy_cnt <= 0;
      if (ramstate[1]) resp_n <= resp_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic done(input int cpu, input bit is_d, input logic [W-1:0] ld);
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else e = mk(-1, 1'b0, 1'b0, 1'b1, '0, '0);
    chk("done_cpu", 64'(cpu), 64'(e.cpu));
    chk("done_kind", 64'(is_d), 64'(e.is_d));
    chk("done_not_err", 64'(e.err), 64'(0));
    chk("done_addr", 64'(ramaddr), 64'(e.addr));
    chk("done_enable", 64'({ramWEN, ramREN}), e.wr ? 64'(2'b10) : 64'(2'b01));
    chk("done_load", 64'(ld), e.wr ? 64'(0) : 64'(e.data));
    if (e.wr) chk("done_store", 64'(ramstore), 64'(e.data));
    if (auto_drop) begin
      if (is_d) drop_d[cpu] = 1'b1;
      else      drop_i[cpu] = 1'b1;
    end
  endtask

  // One clock: requesters withdraw just after the edge that follows their completion, then outputs are sampled.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    dREN = dREN & ~drop_d;
    dWEN = dWEN & ~drop_d;
    iREN = iREN & ~drop_i;
    drop_d = '0;
    drop_i = '0;
    @(negedge CLK);
    chk("ren_wen_excl", 64'(ramREN & ramWEN), 64'(0));
    if (memerr) begin
      chk("err_no_wait", 64'({iwait, dwait}), 64'({(2*N){1'b1}}));
      if (sb.size() > 0) e = sb.pop_front();
      else e = mk(-1, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("err_expected", 64'(e.err), 64'(1));
    end
    for (int i = 0; i < N; i++) begin
      if (!dwait[i]) done(i, 1'b1, dload[i*W +: W]);
      else           chk("dload_idle", 64'(dload[i*W +: W]), 64'(0));
      if (!iwait[i]) done(i, 1'b0, iload[i*W +: W]);
      else           chk("iload_idle", 64'(iload[i*W +: W]), 64'(0));
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_reset();
    chk("rst_waits", 64'({iwait, dwait}), 64'({(2*N){1'b1}}));
    chk("rst_loads", 64'(|{iload, dload}), 64'(0));
    chk("rst_ram_en", 64'({ramREN, ramWEN, memerr}), 64'(0));
    chk("rst_ramaddr", 64'(ramaddr), 64'(0));
    chk("rst_ramstore", 64'(ramstore), 64'(0));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    drop_d = '0; drop_i = '0;
    lat = 0; err_at = -1; auto_drop = 1'b1;
    sb.delete();
    @(negedge CLK);
    @(negedge CLK);
    check_reset();
    RST = 1'b0;
  endtask

  initial begin
    // Single read with two BUSY cycles.
    do_reset();
    lat = 2;
    daddr[0*A +: A] = 32'h40;
    dREN[0] = 1'b1;
    sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF));
    tick(); chk("rd_cycle1", 64'({ramREN, ramWEN, dwait[0]}), 64'(3'b101));
    tick(); chk("rd_cycle2", 64'({ramREN, ramWEN, dwait[0]}), 64'(3'b101));
    tick(); chk("rd_cycle3", 64'({ramREN, ramWEN, dwait[0]}), 64'(3'b100));
    run(3);

    // Write wins over read; address/data changes after grant are ignored.
    do_reset();
    lat = 1;
    daddr[1*A +: A] = 32'h80;
    dstore[1*W +: W] = 32'h1234;
    dREN[1] = 1'b1;
    dWEN[1] = 1'b1;
    sb.push_back(mk(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h1234));
    tick();
    chk("wr_enables", 64'({ramREN, ramWEN}), 64'(2'b01));
    chk("wr_addr", 64'(ramaddr), 64'(32'h80));
    daddr[1*A +: A] = 32'hFFF0;
    dstore[1*W +: W] = 32'h5555;
    run(3);

    // Round robin with every CPU holding a data read.
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) daddr[i*A +: A] = 32'h100 + 32'(i * 4);
    dREN = '1;
    for (int k = 0; k < 5; k++)
      sb.push_back(mk(k % N, 1'b1, 1'b0, 1'b0, 32'h100 + 32'((k % N) * 4),
                      rd_data(32'h100 + 32'((k % N) * 4))));
    repeat (9) tick();
    @(posedge CLK);
    #1 dREN = '0;
    run(3);

    // Data before instruction within a CPU; instruction waits for CPU0's next turn.
    do_reset();
    iaddr[0*A +: A] = 32'h500;
    daddr[0*A +: A] = 32'h504;
    daddr[1*A +: A] = 32'h508;
    iREN[0] = 1'b1;
    dREN[0] = 1'b1;
    dREN[1] = 1'b1;
    sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 32'h504, rd_data(32'h504)));
    sb.push_back(mk(1, 1'b1, 1'b0, 1'b0, 32'h508, rd_data(32'h508)));
    sb.push_back(mk(0, 1'b0, 1'b0, 1'b0, 32'h500, rd_data(32'h500)));
    run(8);

    // RAM error on CPU2: memerr pulse, no wait pulse, request served again.
    do_reset();
    err_at = 0;
    daddr[2*A +: A] = 32'h200;
    dREN[2] = 1'b1;
    sb.push_back(mk(2, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0));
    sb.push_back(mk(2, 1'b1, 1'b0, 1'b0, 32'h200, rd_data(32'h200)));
    tick();
    chk("err_memerr", 64'(memerr), 64'(1));
    chk("err_dwait2", 64'(dwait[2]), 64'(1));
    run(5);

    // Abort: instruction request withdrawn while RAM is busy; pointer must stay at 0.
    do_reset();
    lat = 5;
    iaddr[1*A +: A] = 32'h300;
    iREN[1] = 1'b1;
    tick(); chk("abort_ren", 64'(ramREN), 64'(1));
    tick(); iREN[1] = 1'b0;
    tick(); chk("abort_idle", 64'(ramREN), 64'(0));
    run(3);
    lat = 0;
    daddr[1*A +: A] = 32'h310;
    daddr[2*A +: A] = 32'h320;
    dREN[1] = 1'b1;
    dREN[2] = 1'b1;
    sb.push_back(mk(1, 1'b1, 1'b0, 1'b0, 32'h310, rd_data(32'h310)));
    sb.push_back(mk(2, 1'b1, 1'b0, 1'b0, 32'h320, rd_data(32'h320)));
    run(6);

    // Asynchronous reset in the middle of a write.
    do_reset();
    lat = 5;
    daddr[3*A +: A] = 32'h400;
    dstore[3*W +: W] = 32'hABCD;
    dWEN[3] = 1'b1;
    tick();
    chk("midrst_wen", 64'(ramWEN), 64'(1));
    #2 RST = 1'b1;
    #1 check_reset();
    dWEN = '0;
    @(negedge CLK);
    RST = 1'b0;
    lat = 0;
    daddr[0*A +: A] = 32'h410;
    daddr[3*A +: A] = 32'h420;
    dREN[0] = 1'b1;
    dREN[3] = 1'b1;
    sb.push_back(mk(0, 1'b1, 1'b0, 1'b0, 32'h410, rd_data(32'h410)));
    sb.push_back(mk(3, 1'b1, 1'b0, 1'b0, 32'h420, rd_data(32'h420)));
    run(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
